// File: rtl/jtag_lock_ctrl.sv
// JTAG debug lock sequencer: fixed-latency key check, failure counting and lockout.
// Define JTAG_LOCK_PERM_LOCKOUT_EN to make lockout terminal (exit only via resetn).
module jtag_lock_ctrl #(
  parameter int unsigned KEY_W       = 32,
  parameter int unsigned CMP_LAT     = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 1024
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              unlock_req,
  input  logic [KEY_W-1:0]                  key_in,
  input  logic [KEY_W-1:0]                  fuse_key,
  input  logic                              relock,
  output logic                              lock_jtag_status,
  output logic                              busy,
  output logic                              unlock_ok,
  output logic                              unlock_fail,
  output logic                              lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  localparam logic [1:0] StLocked   = 2'd0;
  localparam logic [1:0] StCheck    = 2'd1;
  localparam logic [1:0] StUnlocked = 2'd2;
  localparam logic [1:0] StLockout  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [FW-1:0]    fail_cnt_q, fail_cnt_d, fail_inc;
  logic             ok_d, fail_d;
  logic             lock_q, busy_q, ok_q, fail_q, lockout_q;

`ifndef JTAG_LOCK_PERM_LOCKOUT_EN
  localparam int unsigned TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  logic [TW-1:0] timer_q, timer_d;
`endif

  assign fail_inc = (fail_cnt_q == FW'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + FW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    fail_cnt_d = fail_cnt_q;
    ok_d       = 1'b0;
    fail_d     = 1'b0;
`ifndef JTAG_LOCK_PERM_LOCKOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      StLocked: begin
        if (unlock_req) begin
          key_d   = key_in;
          cnt_d   = CW'(CMP_LAT - 1);
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Key is wiped on the decision edge whatever the outcome.
          key_d = '0;
          if (key_q == fuse_key) begin
            state_d    = StUnlocked;
            ok_d       = 1'b1;
            fail_cnt_d = '0;
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_inc;
            if (fail_inc == FW'(MAX_FAIL)) begin
              state_d = StLockout;
`ifndef JTAG_LOCK_PERM_LOCKOUT_EN
              timer_d = TW'(LOCKOUT_CYC - 1);
`endif
            end else begin
              state_d = StLocked;
            end
          end
        end
      end
      StUnlocked: begin
        if (relock) state_d = StLocked;
      end
      StLockout: begin
`ifndef JTAG_LOCK_PERM_LOCKOUT_EN
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d    = StLocked;
          fail_cnt_d = '0;
        end
`endif
      end
      default: state_d = StLocked;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= StLocked;
      cnt_q      <= '0;
      key_q      <= '0;
      fail_cnt_q <= '0;
      lock_q     <= 1'b1;
      busy_q     <= 1'b0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      lockout_q  <= 1'b0;
`ifndef JTAG_LOCK_PERM_LOCKOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      fail_cnt_q <= fail_cnt_d;
      // Status outputs are registered copies of the next-state decode.
      lock_q     <= (state_d != StUnlocked);
      busy_q     <= (state_d == StCheck);
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      lockout_q  <= (state_d == StLockout);
`ifndef JTAG_LOCK_PERM_LOCKOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign lock_jtag_status = lock_q;
  assign busy             = busy_q;
  assign unlock_ok        = ok_q;
  assign unlock_fail      = fail_q;
  assign lockout          = lockout_q;
  assign fail_cnt         = fail_cnt_q;

endmodule

// File: tb/tb_jtag_lock_ctrl.sv
// Scoreboard bench for jtag_lock_ctrl: decision pulses are matched against queued expectations.
module tb_jtag_lock_ctrl;

  localparam int unsigned KEY_W       = 32;
  localparam int unsigned CMP_LAT     = 4;
  localparam int unsigned MAX_FAIL    = 3;
  localparam int unsigned LOCKOUT_CYC = 1024;
  localparam logic [31:0] FUSE        = 32'hA5A5_1234;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             unlock_req = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic [KEY_W-1:0] fuse_key = FUSE;
  logic             relock = 1'b0;
  logic             lock_jtag_status, busy, unlock_ok, unlock_fail, lockout;
  logic [1:0]       fail_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    bit ok;
    int cnt;
    int cyc;
  } exp_t;
  exp_t sb[$];

  jtag_lock_ctrl #(
    .KEY_W(KEY_W), .CMP_LAT(CMP_LAT), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .resetn(resetn), .unlock_req(unlock_req), .key_in(key_in),
    .fuse_key(fuse_key), .relock(relock), .lock_jtag_status(lock_jtag_status),
    .busy(busy), .unlock_ok(unlock_ok), .unlock_fail(unlock_fail), .lockout(lockout),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every decision pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (unlock_ok !== 1'b0 || unlock_fail !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, unlock_ok, unlock_fail}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ok", unlock_ok, e.ok);
        check("sb_fail", unlock_fail, !e.ok);
        check("sb_cnt", fail_cnt, e.cnt);
        check("sb_lat", cyc, e.cyc);
      end
    end
  end

  task automatic run_check(input logic [31:0] key, input bit exp_ok, input int exp_cnt,
                           input bit hold_req);
    exp_t e;
    unlock_req = 1'b1;
    key_in     = key;
    e.ok  = exp_ok;
    e.cnt = exp_cnt;
    e.cyc = cyc + 1 + CMP_LAT;
    sb.push_back(e);
    tick();
    key_in = $urandom;
    unlock_req = hold_req;
    relock     = hold_req;
    for (int i = 0; i < CMP_LAT; i++) begin
      check("busy_in_check", busy, 1'b1);
      check("lock_in_check", lock_jtag_status, 1'b1);
      if (i == CMP_LAT - 1) begin
        unlock_req = 1'b0;
        relock     = 1'b0;
      end
      tick();
    end
    check("busy_after", busy, 1'b0);
    check("lock_after", lock_jtag_status, !exp_ok);
    check("cnt_after", fail_cnt, exp_cnt);
    check("lockout_after", lockout, exp_cnt == MAX_FAIL);
    @(negedge clk);
    #1;
    check("pulse_seen", sb.size(), 0);
    if (hold_req) begin
      tick();
      check("no_second_check", busy, 1'b0);
    end
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    check("relock_lock", lock_jtag_status, 1'b1);
  endtask

  task automatic pulse_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check("rst_lock", lock_jtag_status, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_lockout", lockout, 1'b0);
    check("rst_cnt", fail_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state, checked while reset is still held and after release.
    tick();
    tick();
    check("rst_hold_lock", lock_jtag_status, 1'b1);
    check("rst_hold_ok", unlock_ok, 1'b0);
    check("rst_hold_fail", unlock_fail, 1'b0);
    resetn = 1'b0;
    tick();
    check("idle_lock", lock_jtag_status, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_lockout", lockout, 1'b0);
    check("idle_cnt", fail_cnt, 0);

    // Correct key, then relock; relock in LOCKED is a no-op.
    do_relock();
    run_check(FUSE, 1'b1, 0, 1'b0);
    do_relock();

    // Wrong then correct; request/relock held during CHECK are ignored.
    run_check(32'h0, 1'b0, 1, 1'b1);
    run_check(FUSE, 1'b1, 0, 1'b1);

    // Simultaneous request and relock while unlocked: relock wins.
    unlock_req = 1'b1;
    relock     = 1'b1;
    key_in     = FUSE;
    tick();
    unlock_req = 1'b0;
    relock     = 1'b0;
    check("simul_unl_lock", lock_jtag_status, 1'b1);
    check("simul_unl_busy", busy, 1'b0);
    tick();
    check("simul_unl_busy2", busy, 1'b0);

    // Simultaneous request and relock while locked: unlock proceeds.
    relock = 1'b1;
    run_check(FUSE, 1'b1, 0, 1'b0);
    do_relock();

    // Reset two cycles into CHECK aborts with no pulse and clears the count.
    run_check(32'h1, 1'b0, 1, 1'b0);
    unlock_req = 1'b1;
    key_in     = FUSE;
    tick();
    unlock_req = 1'b0;
    tick();
    tick();
    pulse_reset();
    for (int i = 0; i < CMP_LAT + 2; i++) begin
      tick();
      check("abort_busy", busy, 1'b0);
    end
    check("abort_lock", lock_jtag_status, 1'b1);

    // Three failures trigger lockout.
    run_check(32'h0, 1'b0, 1, 1'b0);
    run_check(32'h0, 1'b0, 2, 1'b0);
    run_check(32'h0, 1'b0, 3, 1'b0);
`ifdef JTAG_LOCK_PERM_LOCKOUT_EN
    for (int i = 0; i < 5000; i++) begin
      unlock_req = (i == 100);
      key_in     = FUSE;
      tick();
    end
    unlock_req = 1'b0;
    check("perm_lockout", lockout, 1'b1);
    check("perm_lock", lock_jtag_status, 1'b1);
    check("perm_busy", busy, 1'b0);
    pulse_reset();
`else
    n = 0;
    while (lockout === 1'b1 && n < 3000) begin
      n++;
      if (n == 500) check("lockout_lock", lock_jtag_status, 1'b1);
      unlock_req = (n == 100);
      key_in     = FUSE;
      tick();
    end
    unlock_req = 1'b0;
    check("lockout_len", n, LOCKOUT_CYC);
    check("post_lockout_cnt", fail_cnt, 0);
    check("post_lockout_lock", lock_jtag_status, 1'b1);
    check("post_lockout_busy", busy, 1'b0);
`endif
    run_check(FUSE, 1'b1, 0, 1'b0);
    do_relock();

    tick();
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
